// File: rtl/ysyx_24080006_mdu_ctrl.sv
// ysyx_24080006_mdu_ctrl
// EX-stage requester for the iterative MDU. Latches one multiply/divide op from
// the ID/EX valid/ready stage, holds it stable on the MDU request port until the
// MDU's one-cycle finish strobe, then presents the result to WB with
// valid/ready backpressure. A flush never aborts the MDU mid-op: the op drains
// and its result is dropped.
//
// Optional feature macro: YSYX_24080006_MDU_CACHE_EN
//   When defined, a one-entry last-result cache lets an exact repeat of the
//   previous MDU op skip the MDU entirely.
//
// Ports
//   clock, reset        clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   op handshake from ID/EX
//   in_a, in_b, in_set  operands and op descriptor
//   in_rd               destination register tag
//   flush               kill the in-flight or pending op
//   mdu_a/b/set/valid   registered request to the MDU
//   mdu_ready, mdu_o    MDU finish strobe and result (valid that cycle only)
//   out_valid/out_ready result handshake to WB
//   out_data, out_rd    result and its tag
//   busy                controller not idle (hazard stall to ID)
//   wdog_err            sticky: MDU took longer than WDOG_CYCLES

package ysyx_24080006_mdu_pkg;
    typedef enum logic [1:0] {
        ALU_MULL = 2'd0,
        ALU_MULH = 2'd1,
        ALU_DIV  = 2'd2,
        ALU_REM  = 2'd3
    } mdu_op_t;

    typedef struct packed {
        mdu_op_t op;
        logic    signed_a;
        logic    signed_b;
    } mdu_set_t;
endpackage

// state | meaning
// IDLE  | waiting for an op from ID/EX, in_ready high
// ISSUE | request held on the MDU until mdu_ready
// RESP  | result presented to WB until out_ready or flush
module ysyx_24080006_mdu_ctrl
    import ysyx_24080006_mdu_pkg::*;
#(
    parameter int RD_WIDTH    = 5,
    parameter int WDOG_CYCLES = 48
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_a,
    input  logic [31:0]         in_b,
    input  mdu_set_t            in_set,
    input  logic [RD_WIDTH-1:0] in_rd,
    input  logic                flush,
    output logic [31:0]         mdu_a,
    output logic [31:0]         mdu_b,
    output mdu_set_t            mdu_set,
    output logic                mdu_valid,
    input  logic                mdu_ready,
    input  logic [31:0]         mdu_o,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic [RD_WIDTH-1:0] out_rd,
    output logic                busy,
    output logic                wdog_err
);

    localparam int CW = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    logic          kill;
    logic [CW-1:0] wdog_cnt;
    logic          accept;
    logic          hit;
    logic [31:0]   cached_res;

    assign accept = in_valid & in_ready & ~flush;

`ifdef YSYX_24080006_MDU_CACHE_EN
    logic [31:0] c_a;
    logic [31:0] c_b;
    mdu_set_t    c_set;
    logic        c_vld;

    // Filled from the registered request so a killed op still primes the cache.
    always_ff @(posedge clock) begin
        if (reset) begin
            c_a        <= '0;
            c_b        <= '0;
            c_set      <= '0;
            cached_res <= '0;
            c_vld      <= 1'b0;
        end else if (state == ISSUE && mdu_ready) begin
            c_a        <= mdu_a;
            c_b        <= mdu_b;
            c_set      <= mdu_set;
            cached_res <= mdu_o;
            c_vld      <= 1'b1;
        end
    end

    assign hit = c_vld && (c_a == in_a) && (c_b == in_b) && (c_set == in_set);
`else
    assign hit        = 1'b0;
    assign cached_res = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mdu_valid <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            wdog_err  <= 1'b0;
            kill      <= 1'b0;
            wdog_cnt  <= '0;
            mdu_a     <= '0;
            mdu_b     <= '0;
            mdu_set   <= '0;
            out_data  <= '0;
            out_rd    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mdu_a    <= in_a;
                        mdu_b    <= in_b;
                        mdu_set  <= in_set;
                        out_rd   <= in_rd;
                        kill     <= 1'b0;
                        wdog_cnt <= CW'(WDOG_CYCLES);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (hit) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            out_data  <= cached_res;
                        end else begin
                            state     <= ISSUE;
                            mdu_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Watchdog is a down-counter; terminal count sets the sticky flag.
                    if (wdog_cnt != '0) begin
                        wdog_cnt <= wdog_cnt - CW'(1);
                    end
                    if (wdog_cnt == CW'(1)) begin
                        wdog_err <= 1'b1;
                    end
                    if (mdu_ready) begin
                        // Dropping the request right after the strobe keeps the MDU from restarting.
                        mdu_valid <= 1'b0;
                        out_data  <= mdu_o;
                        if (kill || flush) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                RESP: begin
                    if (flush || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Testbench for ysyx_24080006_mdu_ctrl: stub MDU with programmable latency,
// transaction-level expectation model compared every cycle, plus literal checks.
module tb_ysyx_24080006_mdu_ctrl;
    import ysyx_24080006_mdu_pkg::*;

    localparam int RDW  = 5;
    localparam int WDOG = 48;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_a = '0;
    logic [31:0]     in_b = '0;
    mdu_set_t        in_set = '0;
    logic [RDW-1:0]  in_rd = '0;
    logic            flush = 1'b0;
    logic [31:0]     mdu_a;
    logic [31:0]     mdu_b;
    mdu_set_t        mdu_set;
    logic            mdu_valid;
    logic            mdu_ready = 1'b0;
    logic [31:0]     mdu_o = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_data;
    logic [RDW-1:0]  out_rd;
    logic            busy;
    logic            wdog_err;

    int checks = 0;
    int errors = 0;

    ysyx_24080006_mdu_ctrl #(.RD_WIDTH(RDW), .WDOG_CYCLES(WDOG)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_set(in_set), .in_rd(in_rd),
        .flush(flush),
        .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_set(mdu_set),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_o(mdu_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd),
        .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input mdu_set_t s, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] pa;
        logic signed [65:0] pb;
        logic signed [65:0] p;
        logic sgn;
        pa  = s.signed_a ? {{34{a[31]}}, a} : {34'b0, a};
        pb  = s.signed_b ? {{34{b[31]}}, b} : {34'b0, b};
        p   = pa * pb;
        sgn = s.signed_a & s.signed_b;
        case (s.op)
            ALU_MULL: return p[31:0];
            ALU_MULH: return p[63:32];
            ALU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                if (sgn) return $signed(a) / $signed(b);
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                if (sgn) return $signed(a) % $signed(b);
                return a % b;
            end
        endcase
    endfunction

    // Stub MDU: after the request has been seen for stub_lat cycles it strobes
    // mdu_ready once with the arithmetic result of whatever sits on its port.
    int stub_lat = 3;
    int stub_cnt = 0;
    always @(posedge clock) begin
        if (reset) stub_cnt = 0;
        else if (mdu_valid && !mdu_ready) stub_cnt++;
        else stub_cnt = 0;
        #1;
        if (stub_cnt == stub_lat) begin
            mdu_ready = 1'b1;
            mdu_o     = ref_mdu(mdu_set, mdu_a, mdu_b);
        end else begin
            mdu_ready = 1'b0;
            mdu_o     = 32'hDEAD_BEEF;
        end
    end

    // Expectation model: one op at a time, tracked as "where the op is".
    typedef enum int {FREE, AT_MDU, AT_WB} where_t;
    where_t          m_where = FREE;
    logic            m_live = 1'b0;
    logic            m_doomed = 1'b0;
    int              m_cycles = 0;
    logic [31:0]     m_a = '0, m_b = '0, m_res = '0;
    mdu_set_t        m_set = '0;
    logic            e_in_ready = 1'b0, e_mdu_valid = 1'b0, e_out_valid = 1'b0;
    logic            e_busy = 1'b0, e_wdog = 1'b0;
    logic [31:0]     e_out_data = '0;
    logic [RDW-1:0]  e_out_rd = '0;
`ifdef YSYX_24080006_MDU_CACHE_EN
    logic            mc_vld = 1'b0;
    logic [31:0]     mc_a = '0, mc_b = '0, mc_res = '0;
    mdu_set_t        mc_set = '0;
`endif

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1'b1; m_where = FREE;
            e_in_ready = 1'b0; e_mdu_valid = 1'b0; e_out_valid = 1'b0;
            e_busy = 1'b0; e_wdog = 1'b0; e_out_data = '0; e_out_rd = '0;
`ifdef YSYX_24080006_MDU_CACHE_EN
            mc_vld = 1'b0;
`endif
        end else begin
            case (m_where)
                FREE: begin
                    if (in_valid && e_in_ready && !flush) begin
                        m_a = in_a; m_b = in_b; m_set = in_set;
                        m_res = ref_mdu(in_set, in_a, in_b);
                        e_out_rd = in_rd; e_in_ready = 1'b0; e_busy = 1'b1;
                        m_where = AT_MDU;
`ifdef YSYX_24080006_MDU_CACHE_EN
                        if (mc_vld && mc_a == in_a && mc_b == in_b && mc_set == in_set) begin
                            m_where = AT_WB; e_out_valid = 1'b1; e_out_data = mc_res;
                        end
`endif
                        if (m_where == AT_MDU) begin
                            e_mdu_valid = 1'b1; m_cycles = 0; m_doomed = 1'b0;
                        end
                    end else begin
                        e_in_ready = 1'b1;
                    end
                end
                AT_MDU: begin
                    m_cycles++;
                    if (m_cycles >= WDOG) e_wdog = 1'b1;
                    if (mdu_ready) begin
`ifdef YSYX_24080006_MDU_CACHE_EN
                        mc_vld = 1'b1; mc_a = m_a; mc_b = m_b; mc_set = m_set; mc_res = m_res;
`endif
                        e_mdu_valid = 1'b0;
                        if (m_doomed || flush) begin
                            m_where = FREE; e_in_ready = 1'b1; e_busy = 1'b0;
                        end else begin
                            m_where = AT_WB; e_out_valid = 1'b1; e_out_data = m_res;
                        end
                    end else if (flush) begin
                        m_doomed = 1'b1;
                    end
                end
                default: begin
                    if (flush || out_ready) begin
                        m_where = FREE; e_out_valid = 1'b0; e_in_ready = 1'b1; e_busy = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, e_in_ready});
            chk("mdu_valid", {31'b0, mdu_valid}, {31'b0, e_mdu_valid});
            chk("out_valid", {31'b0, out_valid}, {31'b0, e_out_valid});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("wdog_err", {31'b0, wdog_err}, {31'b0, e_wdog});
            if (e_mdu_valid) begin
                chk("mdu_a", mdu_a, m_a);
                chk("mdu_b", mdu_b, m_b);
                chk("mdu_set", {28'b0, mdu_set}, {28'b0, m_set});
            end
            if (e_out_valid) begin
                chk("out_data", out_data, e_out_data);
                chk("out_rd", {27'b0, out_rd}, {27'b0, e_out_rd});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic mdu_set_t mk(input mdu_op_t op, input logic sa, input logic sb);
        mdu_set_t s;
        s.op = op; s.signed_a = sa; s.signed_b = sb;
        return s;
    endfunction

    task automatic offer(input mdu_set_t s, input logic [31:0] a, input logic [31:0] b, input logic [RDW-1:0] rd);
        int k;
        in_valid = 1'b1; in_a = a; in_b = b; in_set = s; in_rd = rd;
        k = 0;
        while (!in_ready && k < 100) begin
            step(1);
            k++;
        end
        chk("accept_wait", {31'b0, in_ready}, 32'd1);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            step(1);
            k++;
        end
        chk("out_valid_wait", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        step(3);
        reset = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_mdu_valid", {31'b0, mdu_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_mdu_a", mdu_a, 32'd0);
        step(1);
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // MULL 7*6 unsigned
        stub_lat = 3;
        offer(mk(ALU_MULL, 1'b0, 1'b0), 32'd7, 32'd6, 5'd1);
        chk("mull_req", {31'b0, mdu_valid}, 32'd1);
        wait_out();
        chk("mull_data", out_data, 32'd42);
        chk("mull_req_drop", {31'b0, mdu_valid}, 32'd0);
        handshake();
        chk("mull_in_ready", {31'b0, in_ready}, 32'd1);

        // MULH signed -1*-1, DIV signed -7/2
        stub_lat = 5;
        offer(mk(ALU_MULH, 1'b1, 1'b1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_out();
        chk("mulh_data", out_data, 32'h0000_0000);
        handshake();
        stub_lat = 2;
        offer(mk(ALU_DIV, 1'b1, 1'b1), 32'hFFFF_FFF9, 32'd2, 5'd3);
        wait_out();
        chk("div_data", out_data, 32'hFFFF_FFFD);
        chk("div_rd", {27'b0, out_rd}, 32'd3);
        handshake();

        // DIV flushed 3 cycles after accept: drains, result dropped
        stub_lat = 8;
        offer(mk(ALU_DIV, 1'b0, 1'b0), 32'd1000, 32'd3, 5'd4);
        step(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("flush_req_held", {31'b0, mdu_valid}, 32'd1);
        step(12);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_no_out", {31'b0, out_valid}, 32'd0);

        // Backpressure: 5 cycles of out_ready=0 with a new op waiting
        stub_lat = 2;
        offer(mk(ALU_MULL, 1'b0, 1'b0), 32'd3, 32'd5, 5'd5);
        wait_out();
        in_valid = 1'b1; in_a = 32'd2; in_b = 32'd9; in_set = mk(ALU_MULL, 1'b0, 1'b0); in_rd = 5'd6;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", out_data, 32'd15);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            step(1);
        end
        handshake();
        chk("bp_after_in_ready", {31'b0, in_ready}, 32'd1);
        offer(mk(ALU_MULL, 1'b0, 1'b0), 32'd2, 32'd9, 5'd6);
        wait_out();
        chk("bp_next_data", out_data, 32'd18);
        handshake();

        // Flush in RESP
        offer(mk(ALU_REM, 1'b0, 1'b0), 32'd17, 32'd5, 5'd7);
        wait_out();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("resp_flush", {31'b0, out_valid}, 32'd0);

        // Flush in IDLE blocks the accept
        in_valid = 1'b1; in_a = 32'd4; in_b = 32'd4; in_set = mk(ALU_MULL, 1'b0, 1'b0);
        flush = 1'b1;
        step(1);
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {31'b0, busy}, 32'd0);

        // Flush coincident with mdu_ready
        stub_lat = 4;
        offer(mk(ALU_MULL, 1'b0, 1'b0), 32'd11, 32'd13, 5'd8);
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("coinc_out", {31'b0, out_valid}, 32'd0);
        chk("coinc_in_ready", {31'b0, in_ready}, 32'd1);

        // Divide by zero passes through unmodified
        stub_lat = 2;
        offer(mk(ALU_DIV, 1'b0, 1'b0), 32'd5, 32'd0, 5'd9);
        wait_out();
        chk("div0_data", out_data, 32'hFFFF_FFFF);
        handshake();
        offer(mk(ALU_REM, 1'b1, 1'b1), 32'd5, 32'd0, 5'd10);
        wait_out();
        chk("rem0_data", out_data, 32'd5);
        handshake();

        // Watchdog with a stub that never answers
        stub_lat = 1000;
        offer(mk(ALU_DIV, 1'b0, 1'b0), 32'd9, 32'd3, 5'd11);
        step(WDOG - 1);
        chk("wdog_before", {31'b0, wdog_err}, 32'd0);
        step(1);
        chk("wdog_at", {31'b0, wdog_err}, 32'd1);
        chk("wdog_still_req", {31'b0, mdu_valid}, 32'd1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk("wdog_cleared", {31'b0, wdog_err}, 32'd0);
        chk("wdog_rst_req", {31'b0, mdu_valid}, 32'd0);
        chk("wdog_rst_busy", {31'b0, busy}, 32'd0);
        step(1);

        // REM 100 % 7 twice; a repeat hits the cache when it is built in
        stub_lat = 3;
        offer(mk(ALU_REM, 1'b0, 1'b0), 32'd100, 32'd7, 5'd12);
        wait_out();
        chk("rem_data", out_data, 32'd2);
        handshake();
        offer(mk(ALU_REM, 1'b0, 1'b0), 32'd100, 32'd7, 5'd13);
`ifdef YSYX_24080006_MDU_CACHE_EN
        chk("cache_out_valid", {31'b0, out_valid}, 32'd1);
        chk("cache_no_req", {31'b0, mdu_valid}, 32'd0);
`endif
        wait_out();
        chk("rem2_data", out_data, 32'd2);
        chk("rem2_rd", {27'b0, out_rd}, 32'd13);
        handshake();

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
